ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 142 ++++++++++++++
 tb/tb_ifetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch queue between the program counter and the
//               instruction memory. Each slot tracks one fetch address from
//               request to retirement. A redirect (flush) empties the queue
//               and drains the responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc_addr,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra pointer bit separates "full" from "empty" when indices match.
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   alloc_q, alloc_d;
  logic [PTR_W-1:0]   fill_q, fill_d;
  logic [PTR_W-1:0]   retire_q, retire_d;
  logic [PTR_W-1:0]   drop_q, drop_d;
  logic [DEPTH-1:0]   filled_q, filled_d;
  logic [31:0]        pc_q   [DEPTH];
  logic [31:0]        inst_q [DEPTH];

  logic [IDX_W-1:0]   w_aidx, w_fidx, w_ridx;
  logic [PTR_W-1:0]   w_occ, w_outstanding, w_drop_base;
  logic               w_run, w_fill, w_retire;

  assign w_aidx        = alloc_q[IDX_W-1:0];
  assign w_fidx        = fill_q[IDX_W-1:0];
  assign w_ridx        = retire_q[IDX_W-1:0];
  assign w_occ         = alloc_q - retire_q;
  assign w_outstanding = alloc_q - fill_q;
  assign w_run         = (state_q == RUN);
  // In DRAIN the pointers are already zero, so the carried count is drop_q.
  assign w_drop_base   = w_run ? w_outstanding : drop_q;

  // Handshake outputs, slot updates and FSM next state.
  always_comb begin
    imem_req_valid = pc_valid & w_run & ~flush & (w_occ < DEPTH_PTR);
    imem_req_addr  = pc_addr;
    pc_ready       = imem_req_valid & imem_req_ready;
    out_valid      = filled_q[w_ridx] & (retire_q != alloc_q) & ~flush;
    out_inst       = out_valid ? inst_q[w_ridx] : 32'h0;
    out_pc         = out_valid ? pc_q[w_ridx] : 32'h0;
    // A response with nothing outstanding is a protocol violation and ignored.
    w_fill         = imem_resp_valid & w_run & ~flush & (fill_q != alloc_q);
    w_retire       = out_valid & out_ready;

    state_d  = state_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    retire_d = retire_q;
    drop_d   = drop_q;
    filled_d = filled_q;

    if (flush) begin
      alloc_d  = '0;
      fill_d   = '0;
      retire_d = '0;
      filled_d = '0;
      drop_d   = (imem_resp_valid && (w_drop_base != '0)) ? (w_drop_base - PTR_ONE) : w_drop_base;
      state_d  = (drop_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - PTR_ONE;
      end
      if (drop_d == '0) begin
        state_d = RUN;
      end
    end else begin
      if (w_retire) begin
        retire_d         = retire_q + PTR_ONE;
        filled_d[w_ridx] = 1'b0;
      end
      if (pc_ready) begin
        alloc_d          = alloc_q + PTR_ONE;
        filled_d[w_aidx] = 1'b0;
      end
      if (w_fill) begin
        fill_d           = fill_q + PTR_ONE;
        filled_d[w_fidx] = 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      alloc_q  <= '0;
      fill_q   <= '0;
      retire_q <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      state_q  <= state_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // Slot payload storage; validity is carried by filled_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (pc_ready) begin
      pc_q[w_aidx] <= pc_addr;
    end
    if (w_fill) begin
      inst_q[w_fidx] <= imem_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue: a vector table, directed
//               corner sequences and a randomized run against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc_addr;
    logic        flush;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_ready;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_req_valid;
    logic        e_pc_ready;
    logic        e_out_valid;
    logic [31:0] e_out_pc;
    logic [31:0] e_out_inst;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        pc_ready;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_valid        (pc_valid),
    .pc_addr         (pc_addr),
    .pc_ready        (pc_ready),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: addresses awaiting data, delivered {pc,inst} pairs,
  // and the number of in-flight responses still to be thrown away.
  logic [31:0] pend_q[$];
  logic [31:0] rdy_pc[$];
  logic [31:0] rdy_inst[$];
  int          drop_m = 0;
  // Memory side: every accepted address until its response is returned.
  logic [31:0] mem_q[$];

  logic        obs_req_valid, obs_pc_ready, obs_out_valid;
  logic [31:0] obs_out_pc, obs_out_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (~a) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rsp_data();
    return (mem_q.size() != 0) ? inst_of(mem_q[0]) : 32'h0;
  endfunction

  function automatic logic rsp_ok();
    return mem_q.size() != 0;
  endfunction

  function automatic stim_t st(input logic r, input logic pv, input logic [31:0] pa,
                               input logic fl, input logic rr, input logic rv,
                               input logic [31:0] rd, input logic ordy);
    stim_t s;
    s.rst = r; s.pc_valid = pv; s.pc_addr = pa; s.flush = fl;
    s.req_ready = rr; s.resp_valid = rv; s.resp_data = rd; s.out_ready = ordy;
    return s;
  endfunction

  function automatic vec_t vec(input stim_t s, input logic rv, input logic pr,
                               input logic ov, input logic [31:0] opc, input logic [31:0] oin);
    vec_t v;
    v.s = s; v.e_req_valid = rv; v.e_pc_ready = pr;
    v.e_out_valid = ov; v.e_out_pc = opc; v.e_out_inst = oin;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic step(input stim_t s);
    logic m_rv, m_pr, m_ov;
    int   d;
    @(negedge clk);
    rst             = s.rst;
    pc_valid        = s.pc_valid;
    pc_addr         = s.pc_addr;
    flush           = s.flush;
    imem_req_ready  = s.req_ready;
    imem_resp_valid = s.resp_valid;
    imem_resp_data  = s.resp_data;
    out_ready       = s.out_ready;
    #1;
    m_rv = s.pc_valid && (drop_m == 0) && !s.flush && ((pend_q.size() + rdy_pc.size()) < DEPTH);
    m_pr = m_rv && s.req_ready;
    m_ov = (rdy_pc.size() != 0) && !s.flush;
    obs_req_valid = imem_req_valid;
    obs_pc_ready  = pc_ready;
    obs_out_valid = out_valid;
    obs_out_pc    = out_pc;
    obs_out_inst  = out_inst;
    if (s.rst) begin
      chk1("model_req_valid", imem_req_valid, m_rv);
      chk1("model_pc_ready", pc_ready, m_pr);
      chk1("model_out_valid", out_valid, m_ov);
      if (m_rv) chk32("model_req_addr", imem_req_addr, s.pc_addr);
      if (m_ov) begin
        chk32("model_out_pc", out_pc, rdy_pc[0]);
        chk32("model_out_inst", out_inst, rdy_inst[0]);
      end
    end
    if (!s.rst) begin
      pend_q.delete(); rdy_pc.delete(); rdy_inst.delete(); mem_q.delete();
      drop_m = 0;
    end else begin
      if (s.flush) begin
        d = drop_m + pend_q.size();
        if (s.resp_valid && d > 0) d--;
        drop_m = d;
        pend_q.delete(); rdy_pc.delete(); rdy_inst.delete();
      end else if (drop_m > 0) begin
        if (s.resp_valid) drop_m--;
      end else begin
        if (m_ov && s.out_ready) begin
          void'(rdy_pc.pop_front());
          void'(rdy_inst.pop_front());
        end
        if (s.resp_valid && pend_q.size() != 0) begin
          rdy_pc.push_back(pend_q.pop_front());
          rdy_inst.push_back(s.resp_data);
        end
        if (m_pr) pend_q.push_back(s.pc_addr);
      end
      if (s.resp_valid && mem_q.size() != 0) void'(mem_q.pop_front());
      if (m_pr) mem_q.push_back(s.pc_addr);
    end
  endtask

  // Return every outstanding response and pop every delivered word.
  task automatic drain_all();
    int n = 0;
    while ((mem_q.size() != 0 || rdy_pc.size() != 0 || pend_q.size() != 0) && n < 60) begin
      step(st(1, 0, 32'h0, 0, 1, rsp_ok(), rsp_data(), 1));
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL drain_timeout: cycles %0d limit 60", n);
    end
  endtask

  vec_t vt[7];
  int   acc;
  logic seen_ov, seen_rv;
  stim_t rs;

  initial begin
    rst = 1'b0; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;

    // In-order delivery, responses two cycles after acceptance.
    vt[0] = vec(st(1, 1, 32'h0, 0, 1, 0, 32'h0, 1),        1, 1, 0, 32'h0, 32'h0);
    vt[1] = vec(st(1, 1, 32'h4, 0, 1, 0, 32'h0, 1),        1, 1, 0, 32'h0, 32'h0);
    vt[2] = vec(st(1, 1, 32'h8, 0, 1, 1, inst_of(0), 1),   1, 1, 0, 32'h0, 32'h0);
    vt[3] = vec(st(1, 0, 32'h0, 0, 1, 1, inst_of(4), 1),   0, 0, 1, 32'h0, inst_of(0));
    vt[4] = vec(st(1, 0, 32'h0, 0, 1, 1, inst_of(8), 1),   0, 0, 1, 32'h4, inst_of(4));
    vt[5] = vec(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1),        0, 0, 1, 32'h8, inst_of(8));
    vt[6] = vec(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1),        0, 0, 0, 32'h0, 32'h0);

    step(st(0, 0, 32'h0, 0, 0, 0, 32'h0, 0));
    step(st(0, 0, 32'h0, 0, 0, 0, 32'h0, 0));
    step(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1));
    chk1("reset_out_valid", obs_out_valid, 1'b0);
    chk1("reset_pc_ready", obs_pc_ready, 1'b0);
    chk1("reset_req_valid", obs_req_valid, 1'b0);

    foreach (vt[i]) begin
      step(vt[i].s);
      chk1($sformatf("vec%0d_req_valid", i), obs_req_valid, vt[i].e_req_valid);
      chk1($sformatf("vec%0d_pc_ready", i), obs_pc_ready, vt[i].e_pc_ready);
      chk1($sformatf("vec%0d_out_valid", i), obs_out_valid, vt[i].e_out_valid);
      if (vt[i].e_out_valid) begin
        chk32($sformatf("vec%0d_out_pc", i), obs_out_pc, vt[i].e_out_pc);
        chk32($sformatf("vec%0d_out_inst", i), obs_out_inst, vt[i].e_out_inst);
      end
    end
    drain_all();

    // Back-pressure: exactly DEPTH accepted, then one pop frees one slot.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step(st(1, 1, 32'h200 + 32'(4 * i), 0, 1, 0, 32'h0, 0));
      acc += int'(obs_pc_ready);
    end
    chk32("full_accepts", 32'(acc), 32'd4);
    chk1("full_pc_ready", obs_pc_ready, 1'b0);
    for (int i = 0; i < 4; i++) step(st(1, 0, 32'h0, 0, 1, 1, rsp_data(), 0));
    step(st(1, 1, 32'h300, 0, 1, 0, 32'h0, 1));
    chk1("pop_out_valid", obs_out_valid, 1'b1);
    chk32("pop_out_pc", obs_out_pc, 32'h200);
    chk1("pop_no_accept", obs_pc_ready, 1'b0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step(st(1, 1, 32'h300 + 32'(4 * i), 0, 1, 0, 32'h0, 0));
      acc += int'(obs_pc_ready);
    end
    chk32("after_pop_accepts", 32'(acc), 32'd1);
    drain_all();

    // Flush with three outstanding and no response: three drops, then resume.
    for (int i = 0; i < 3; i++) step(st(1, 1, 32'h40 + 32'(4 * i), 0, 1, 0, 32'h0, 1));
    step(st(1, 0, 32'h0, 1, 1, 0, 32'h0, 1));
    seen_ov = 1'b0; seen_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(st(1, 1, 32'h100, 0, 1, 1, rsp_data(), 1));
      seen_ov |= obs_out_valid;
      seen_rv |= obs_req_valid;
    end
    chk1("drain_out_valid", seen_ov, 1'b0);
    chk1("drain_req_valid", seen_rv, 1'b0);
    step(st(1, 1, 32'h100, 0, 1, 0, 32'h0, 1));
    chk1("resume_accept", obs_pc_ready, 1'b1);
    step(st(1, 0, 32'h0, 0, 1, 1, rsp_data(), 1));
    step(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1));
    chk1("resume_out_valid", obs_out_valid, 1'b1);
    chk32("resume_out_pc", obs_out_pc, 32'h100);
    chk32("resume_out_inst", obs_out_inst, inst_of(32'h100));
    drain_all();

    // Flush coincident with a response and two outstanding: one more drop.
    for (int i = 0; i < 2; i++) step(st(1, 1, 32'h500 + 32'(4 * i), 0, 1, 0, 32'h0, 1));
    step(st(1, 0, 32'h0, 1, 1, 1, rsp_data(), 1));
    step(st(1, 1, 32'h600, 0, 0, 1, rsp_data(), 1));
    chk1("drop1_req_valid", obs_req_valid, 1'b0);
    step(st(1, 1, 32'h600, 0, 0, 0, 32'h0, 1));
    chk1("drop1_resume_req_valid", obs_req_valid, 1'b1);
    drain_all();

    // Steady streaming across pointer wrap: alloc, fill and retire together.
    for (int i = 0; i < 2 * DEPTH + 6; i++) begin
      step(st(1, 1, 32'h700 + 32'(4 * i), 0, 1, rsp_ok(), rsp_data(), 1));
      if (i >= 2) begin
        chk1("wrap_pc_ready", obs_pc_ready, 1'b1);
        chk1("wrap_out_valid", obs_out_valid, 1'b1);
        chk32("wrap_out_pc", obs_out_pc, 32'h700 + 32'(4 * (i - 2)));
      end
    end
    drain_all();

    // Mid-stream reset, then a clean fetch from address zero.
    for (int i = 0; i < 3; i++) step(st(1, 1, 32'h900 + 32'(4 * i), 0, 1, rsp_ok(), rsp_data(), 1));
    step(st(0, 0, 32'h0, 0, 1, 0, 32'h0, 1));
    step(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1));
    chk1("mid_rst_out_valid", obs_out_valid, 1'b0);
    chk1("mid_rst_pc_ready", obs_pc_ready, 1'b0);
    chk1("mid_rst_req_valid", obs_req_valid, 1'b0);
    step(st(1, 1, 32'h0, 0, 1, 0, 32'h0, 1));
    chk1("post_rst_accept", obs_pc_ready, 1'b1);
    step(st(1, 0, 32'h0, 0, 1, 1, rsp_data(), 1));
    step(st(1, 0, 32'h0, 0, 1, 0, 32'h0, 1));
    chk1("post_rst_out_valid", obs_out_valid, 1'b1);
    chk32("post_rst_out_pc", obs_out_pc, 32'h0);
    chk32("post_rst_out_inst", obs_out_inst, inst_of(32'h0));
    drain_all();

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 1500; i++) begin
      rs.rst        = ($urandom_range(0, 199) != 0);
      rs.flush      = ($urandom_range(0, 24) == 0);
      rs.pc_valid   = ($urandom_range(0, 3) != 0);
      rs.pc_addr    = $urandom & 32'hFFFF_FFFC;
      rs.req_ready  = ($urandom_range(0, 3) != 0);
      rs.resp_valid = rsp_ok() && ($urandom_range(0, 2) != 0);
      rs.resp_data  = rs.resp_valid ? rsp_data() : $urandom;
      rs.out_ready  = ($urandom_range(0, 2) != 0);
      step(rs);
    end
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
